// File: rtl/regfile_mp_pkg.sv
// regfile_pkg: shared defaults and types for the multi-port register file.
//   DEF_DATA_W / DEF_NUM_REGS / DEF_ZERO_REG : default geometry
//   reg_addr_t / reg_data_t                  : address/data types at default geometry
//   isPow2()                                 : elaboration-time parameter check helper
package regfile_pkg;

  localparam int unsigned DEF_DATA_W   = 64;
  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_ZERO_REG = 31;
  localparam int unsigned DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

  function automatic logic isPow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: decode/writeback bus of the register file.
//   master : pipeline side (drives addresses, writes, issue; reads data/busy)
//   slave  : register file side
// Read/write ports are packed; port k occupies [k*W +: W].
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2
);
  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*ADDR_W-1:0] wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic                     issue_en;
  logic [ADDR_W-1:0]        issue_addr;
  logic                     any_busy;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    input  rd_data, rd_busy, any_busy
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, issue_en, issue_addr,
    output rd_data, rd_busy, any_busy
  );

endinterface

// File: rtl/regfile_wr_arb.sv
// regfile_wr_arb: write-port priority resolver for one query address.
//   wrEn/wrAddr/wrData : packed write ports
//   qAddr              : address being resolved
//   hit/hitData        : some enabled port targets qAddr; data of the
//                        highest-index such port. Never hits ZERO_REG.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = DEF_ZERO_REG
) (
  input  logic [NUM_WR-1:0]        wrEn,
  input  logic [NUM_WR*ADDR_W-1:0] wrAddr,
  input  logic [NUM_WR*DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0]        qAddr,
  output logic                     hit,
  output logic [DATA_W-1:0]        hitData
);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  always_comb begin
    hit     = 1'b0;
    hitData = '0;
    // Ascending scan: a later (higher) port overrides an earlier match.
    for (int unsigned p = 0; p < NUM_WR; p++) begin
      if (wrEn[p] && (wrAddr[p*ADDR_W +: ADDR_W] == qAddr)) begin
        hit     = 1'b1;
        hitData = wrData[p*DATA_W +: DATA_W];
      end
    end
    if (qAddr == ZERO_A) begin
      hit     = 1'b0;
      hitData = '0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read / multi-write register file with a
// per-register busy scoreboard.
//   clk, reset : clock; synchronous active-high reset
//   bus        : regfile_mp_if.slave (reads, writes, issue, any_busy)
// Optional: define REGFILE_MP_BYPASS_EN to forward same-cycle write data to
// matching reads (and suppress rd_busy unless the address is also issued).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 2,
  parameter int unsigned ZERO_REG = DEF_ZERO_REG,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
  input logic          clk,
  input logic          reset,
  regfile_mp_if.slave  bus
);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  if (!isPow2(NUM_REGS) || NUM_REGS < 4) begin : gBadRegs
    $error("regfile_mp: NUM_REGS must be a power of two >= 4");
  end
  if (NUM_RD < 1 || NUM_RD > 4) begin : gBadRd
    $error("regfile_mp: NUM_RD must be 1..4");
  end
  if (NUM_WR < 1 || NUM_WR > 2) begin : gBadWr
    $error("regfile_mp: NUM_WR must be 1..2");
  end
  if (ZERO_REG >= NUM_REGS) begin : gBadZero
    $error("regfile_mp: ZERO_REG out of range");
  end
  if (DATA_W < 1) begin : gBadWidth
    $error("regfile_mp: DATA_W must be >= 1");
  end

  logic [DATA_W-1:0] regs  [NUM_REGS];
  logic [DATA_W-1:0] wrVal [NUM_REGS];
  logic [NUM_REGS-1:0] wrHit;
  logic [NUM_REGS-1:0] busy;
  logic [ADDR_W-1:0]   rdAddr [NUM_RD];

  // One resolver per architectural register gives its next-state write.
  for (genvar a = 0; a < NUM_REGS; a++) begin : gArb
    regfile_wr_arb #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG)
    ) uArb (
      .wrEn   (bus.wr_en),
      .wrAddr (bus.wr_addr),
      .wrData (bus.wr_data),
      .qAddr  (ADDR_W'(a)),
      .hit    (wrHit[a]),
      .hitData(wrVal[a])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '{default: '0};
      busy <= '0;
    end else begin
      for (int unsigned a = 0; a < NUM_REGS; a++) begin
        if (wrHit[a]) regs[a] <= wrVal[a];
        // Issue dominates a same-cycle write: the new producer is in flight.
        if (bus.issue_en && (bus.issue_addr == ADDR_W'(a)) && (a != ZERO_REG))
          busy[a] <= 1'b1;
        else if (wrHit[a])
          busy[a] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : gRdAddr
    assign rdAddr[k] = bus.rd_addr[k*ADDR_W +: ADDR_W];
  end

`ifdef REGFILE_MP_BYPASS_EN
  logic [NUM_RD-1:0] bypHit;
  logic [DATA_W-1:0] bypData [NUM_RD];

  for (genvar k = 0; k < NUM_RD; k++) begin : gByp
    regfile_wr_arb #(
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W),
      .NUM_WR  (NUM_WR),
      .ZERO_REG(ZERO_REG)
    ) uBypArb (
      .wrEn   (bus.wr_en),
      .wrAddr (bus.wr_addr),
      .wrData (bus.wr_data),
      .qAddr  (rdAddr[k]),
      .hit    (bypHit[k]),
      .hitData(bypData[k])
    );
  end
`endif

  logic [NUM_RD*DATA_W-1:0] rdDataFlat;
  logic [NUM_RD-1:0]        rdBusyV;

  always_comb begin
    rdDataFlat = '0;
    rdBusyV    = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rdDataFlat[k*DATA_W +: DATA_W] = (rdAddr[k] == ZERO_A) ? '0 : regs[rdAddr[k]];
      rdBusyV[k] = busy[rdAddr[k]];
`ifdef REGFILE_MP_BYPASS_EN
      // Forwarded data is the producer's result, so busy is no longer
      // meaningful unless a new producer is issued to the same register.
      if (bypHit[k]) begin
        rdDataFlat[k*DATA_W +: DATA_W] = bypData[k];
        if (!(bus.issue_en && (bus.issue_addr == rdAddr[k])))
          rdBusyV[k] = 1'b0;
      end
`endif
    end
  end

  assign bus.rd_data  = rdDataFlat;
  assign bus.rd_busy  = rdBusyV;
  assign bus.any_busy = |busy;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp (default geometry).
// Expectations for same-cycle reads follow REGFILE_MP_BYPASS_EN.
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam logic [63:0] K = 64'h0000010204080001;

  logic clk = 1'b0;
  logic reset;
  always #50 clk = ~clk;

  regfile_mp_if #(.DATA_W(64), .NUM_REGS(32), .NUM_RD(2), .NUM_WR(2)) bus ();

  regfile_mp #(
    .DATA_W  (64),
    .NUM_REGS(32),
    .NUM_RD  (2),
    .NUM_WR  (2),
    .ZERO_REG(31)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;
  reg_data_t   model [32];
`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en    = '0;
    bus.issue_en = 1'b0;
  endtask

  task automatic setWr(input int p, input int a, input logic [63:0] d);
    bus.wr_en[p]             = 1'b1;
    bus.wr_addr[p*5 +: 5]    = 5'(a);
    bus.wr_data[p*64 +: 64]  = d;
  endtask

  task automatic setRd(input int a0, input int a1);
    bus.rd_addr[0 +: 5] = 5'(a0);
    bus.rd_addr[5 +: 5] = 5'(a1);
  endtask

  // Reads two registers per cycle and compares against the bench model.
  task automatic chkAll(input string pfx);
    for (int j = 0; j < 16; j++) begin
      setRd(2*j, 2*j+1);
      #1;
      chk($sformatf("%s_r%0d", pfx, 2*j),   bus.rd_data[0 +: 64],  model[2*j]);
      chk($sformatf("%s_r%0d", pfx, 2*j+1), bus.rd_data[64 +: 64], model[2*j+1]);
      tick();
    end
  endtask

  initial begin
    logic [63:0] old;
    for (int i = 0; i < 32; i++) model[i] = '0;

    // Reset with writes and issue asserted: all must be ignored.
    reset          = 1'b1;
    bus.wr_en      = '1;
    bus.wr_addr    = {5'd4, 5'd3};
    bus.wr_data    = '1;
    bus.issue_en   = 1'b1;
    bus.issue_addr = 5'd3;
    bus.rd_addr    = '0;
    tick();
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("rst_any_busy", 64'(bus.any_busy), 64'd0);
    chk("rst_rd_busy",  64'(bus.rd_busy),  64'd0);
    chkAll("rst");

    // Zero register: writes discarded, issue ignored.
    setWr(0, 31, 64'hA0);
    setWr(1, 31, 64'hA0);
    tick();
    idle();
    setRd(31, 31);
    #1;
    chk("zero_rd0", bus.rd_data[0 +: 64],  64'd0);
    chk("zero_rd1", bus.rd_data[64 +: 64], 64'd0);
    bus.issue_en   = 1'b1;
    bus.issue_addr = 5'd31;
    tick();
    idle();
    chk("zero_busy", 64'(bus.rd_busy),  64'd0);
    chk("zero_any",  64'(bus.any_busy), 64'd0);

    // Pattern: alternate ports, one write per cycle.
    for (int i = 0; i < 31; i++) begin
      idle();
      setWr(i % 2, i, 64'(i) * K);
      tick();
      model[i] = 64'(i) * K;
    end
    idle();
    chkAll("pat");

    // Same-address conflict: port 1 wins.
    setWr(0, 5, 64'h1111);
    setWr(1, 5, 64'h2222);
    tick();
    idle();
    model[5] = 64'h2222;
    setRd(5, 5);
    #1;
    chk("conflict", bus.rd_data[0 +: 64], 64'h2222);

    // Scoreboard.
    bus.issue_en   = 1'b1;
    bus.issue_addr = 5'd7;
    tick();
    idle();
    setRd(7, 0);
    #1;
    chk("sb_issue_busy", 64'(bus.rd_busy[0]), 64'd1);
    chk("sb_issue_any",  64'(bus.any_busy),   64'd1);
    setWr(0, 7, 64'h77);
    #1;
    chk("sb_clear_samecyc", 64'(bus.rd_busy[0]), BYP ? 64'd0 : 64'd1);
    tick();
    idle();
    model[7] = 64'h77;
    chk("sb_clear_busy", 64'(bus.rd_busy[0]), 64'd0);
    chk("sb_clear_data", bus.rd_data[0 +: 64], 64'h77);
    bus.issue_en   = 1'b1;
    bus.issue_addr = 5'd7;
    setWr(1, 7, 64'h99);
    tick();
    idle();
    model[7] = 64'h99;
    chk("sb_both_busy", 64'(bus.rd_busy[0]), 64'd1);
    chk("sb_both_data", bus.rd_data[0 +: 64], 64'h99);
    chk("sb_both_any",  64'(bus.any_busy),    64'd1);
    setWr(0, 7, 64'hAB);
    tick();
    idle();
    model[7] = 64'hAB;
    chk("sb_final_busy", 64'(bus.rd_busy[0]), 64'd0);
    chk("sb_final_any",  64'(bus.any_busy),   64'd0);

    // Glitch: write activity only between edges must not change state.
    bus.wr_en   = '1;
    bus.wr_data = '1;
    for (int i = 0; i < 32; i++) begin
      bus.wr_addr = {5'(31 - i), 5'(i)};
      #1;
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      bus.wr_addr = {5'(i), 5'(31 - i)};
      #1;
    end
    bus.wr_en = '0;
    tick();
    chkAll("glitch");

    // Read-during-write of reg 3.
    old = model[3];
    setWr(0, 3, 64'hDEAD);
    setRd(3, 3);
    #1;
    chk("bypass_same", bus.rd_data[0 +: 64], BYP ? 64'hDEAD : old);
    tick();
    idle();
    model[3] = 64'hDEAD;
    chk("bypass_next", bus.rd_data[0 +: 64], 64'hDEAD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
